// File: rtl/rpn_pkg.sv
// rpn_pkg: shared state encoding, field widths and flag positions for the RPN sequencer
package rpn_pkg;
  typedef enum logic [1:0] {
    ST_ENTRA_A = 2'b00,
    ST_ENTRA_B = 2'b01,
    ST_OPERA   = 2'b10,
    ST_MOSTRA  = 2'b11
  } estado_t;
  localparam int OPCODE_W = 3;
  localparam int FLAGS_W  = 4;
  localparam int FLAG_C   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_N   = 1;
  localparam int FLAG_V   = 0;
endpackage

// File: rtl/detector_borda_subida.sv
// detector_borda_subida: rising-edge pulse; history resets high so a level held through reset is not a press
module detector_borda_subida (
  input  logic clk,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);
  logic sinal_q;
  always_ff @(posedge clk)
    if (reset) sinal_q <= 1'b1;
    else sinal_q <= sinal;
  assign pulso = sinal & ~sinal_q;
endmodule

// File: rtl/sequenciador_rpn.sv
// sequenciador_rpn: RPN front-end sequencer for the ALU; define RPN_CHAIN_EN to chain the result into the next operand A.
module sequenciador_rpn
  import rpn_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CICLOS = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enter,
  input  logic [WIDTH-1:0]    dado_in,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                alu_start,
  input  logic                alu_valid,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [FLAGS_W-1:0]  alu_flags,
  output logic [WIDTH-1:0]    resultado,
  output logic [FLAGS_W-1:0]  flags,
  output logic [1:0]          estado,
  output logic                erro
);
  localparam int CNT_W = 8;
  logic                pulso;
  estado_t             estado_q, estado_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [FLAGS_W-1:0]  flags_q, flags_d;
  logic                erro_q, erro_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  detector_borda_subida u_borda (.clk(clk), .reset(reset), .sinal(enter), .pulso(pulso));

  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    flags_d  = flags_q;
    erro_d   = erro_q;
    cnt_d    = cnt_q;
    case (estado_q)
      ST_ENTRA_A: if (pulso) begin
        a_d      = dado_in;
        estado_d = ST_ENTRA_B;
      end
      ST_ENTRA_B: if (pulso) begin
        b_d      = dado_in;
        op_d     = opcode;
        cnt_d    = '0;
        estado_d = ST_OPERA;
      end
      ST_OPERA: begin
        cnt_d = cnt_q + 1'b1;
        if (alu_valid) begin
          res_d    = alu_result;
          flags_d  = alu_flags;
          erro_d   = 1'b0;
          estado_d = ST_MOSTRA;
        end else if (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1)) begin
          res_d    = '0;
          flags_d  = '0;
          erro_d   = 1'b1;
          estado_d = ST_MOSTRA;
        end
      end
      ST_MOSTRA: if (pulso) begin
        erro_d = 1'b0;
`ifdef RPN_CHAIN_EN
        a_d      = erro_q ? a_q : res_q;
        estado_d = erro_q ? ST_ENTRA_A : ST_ENTRA_B;
`else
        estado_d = ST_ENTRA_A;
`endif
      end
    endcase
  end

  always_ff @(posedge clk)
    if (reset) begin
      estado_q <= ST_ENTRA_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      erro_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      erro_q   <= erro_d;
      cnt_q    <= cnt_d;
    end

  // counter is cleared on entry, so zero marks the first OPERA cycle
  assign alu_start = (estado_q == ST_OPERA) && (cnt_q == '0);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign resultado = res_q;
  assign flags     = flags_q;
  assign erro      = erro_q;
  assign estado    = estado_q;
endmodule

// File: tb/tb_sequenciador_rpn.sv
// tb_sequenciador_rpn: scoreboard bench with a behavioural ALU and transaction model
module tb_sequenciador_rpn;
  localparam int TO = 15;
`ifdef RPN_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  logic clk = 0, reset = 1, enter = 0, alu_valid = 0;
  logic [7:0] dado_in = 0, alu_result = 0, alu_a, alu_b, resultado;
  logic [2:0] opcode = 0, alu_op;
  logic [3:0] alu_flags = 0, flags;
  logic [1:0] estado;
  logic alu_start, erro;
  int total = 0, bad = 0, cur_lat = 1;

  typedef struct {
    logic [7:0] r, a, b;
    logic [3:0] f;
    logic [2:0] op;
    logic e;
    int el;
  } exp_t;
  exp_t q[$];

  sequenciador_rpn dut (
    .clk(clk), .reset(reset), .enter(enter), .dado_in(dado_in), .opcode(opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_flags(alu_flags),
    .resultado(resultado), .flags(flags), .estado(estado), .erro(erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    s = 0; c = 0; v = 0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a << 1; c = a[7]; end
      3'd6: begin r = a >> 1; c = a[0]; end
      default: r = a;
    endcase
    return {c, r == 8'd0, r[7], v, r};
  endfunction

  // ALU model: answers cur_lat cycles after the request, random noise when idle
  int k = 0;
  always @(negedge clk) begin
    if (reset) begin
      k = 0;
      alu_valid = 0;
    end else begin
      if (alu_start) k = 1;
      else if (k != 0) k = (k >= TO) ? 0 : k + 1;
      if (k != 0) begin
        alu_valid = (k == cur_lat);
        {alu_flags, alu_result} = (k == cur_lat) ? alu_f(alu_a, alu_b, alu_op) : 12'($urandom);
        if (k == cur_lat) k = 0;
      end else begin
        alu_valid = ($urandom_range(3) == 0);
        {alu_flags, alu_result} = 12'($urandom);
      end
    end
  end

  // monitor: pops one expectation per entry into the display state
  int ocnt = 0, starts = 0;
  logic [1:0] prev = 0;
  always @(negedge clk) begin
    if (reset) begin
      ocnt = 0; starts = 0; prev = 0;
    end else begin
      if (alu_start) starts++;
      if (ocnt != 0 || alu_start) ocnt++;
      if (estado == 2'b11 && prev != 2'b11) begin
        chk("sb_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("resultado", resultado, e.r);
          chk("flags", flags, e.f);
          chk("erro", erro, e.e);
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
          chk("alu_op", alu_op, e.op);
          chk("start_pulses", starts, 1);
          chk("latency", ocnt - 1, e.el);
        end
        ocnt = 0; starts = 0;
      end
      prev = estado;
    end
  end

  task automatic press(input logic [7:0] d, input logic [2:0] op);
    @(negedge clk);
    dado_in = d; opcode = op; enter = 1;
    @(negedge clk);
    enter = 0; dado_in = 8'($urandom); opcode = 3'($urandom);
  endtask

  logic [1:0] mdl_st = 0;
  logic [7:0] mdl_a = 0;

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int lat);
    exp_t e;
    logic [11:0] fr;
    int n;
    if (mdl_st == 0) begin
      press(a, 3'($urandom));
      mdl_a = a;
      chk("estado_after_a", estado, 1);
    end
    cur_lat = lat;
    fr = alu_f(mdl_a, b, op);
    e.a = mdl_a; e.b = b; e.op = op;
    e.e = (lat > TO);
    e.r = e.e ? 8'd0 : fr[7:0];
    e.f = e.e ? 4'd0 : fr[11:8];
    e.el = e.e ? TO : lat;
    q.push_back(e);
    press(b, op);
    if (lat >= 3) begin
      @(negedge clk); enter = 1; dado_in = 8'($urandom);
      @(negedge clk); enter = 0;
      chk("opera_ignores_enter", estado, 2);
    end
    for (n = 0; n < 40 && estado != 2'b11; n++) @(negedge clk);
    chk("reached_mostra", estado, 3);
    repeat ($urandom_range(3)) @(negedge clk);
    chk("mostra_hold_res", resultado, e.r);
    press(8'($urandom), 3'($urandom));
    mdl_st = (CHAIN && !e.e) ? 2'd1 : 2'd0;
    if (CHAIN && !e.e) mdl_a = e.r;
    chk("exit_estado", estado, mdl_st);
    chk("exit_erro", erro, 0);
    chk("exit_alu_a", alu_a, mdl_a);
  endtask

  initial begin
    enter = 1; dado_in = 8'hA5; reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_estado", estado, 0);
    chk("rst_ab", {alu_a, alu_b}, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_res", {resultado, flags, erro}, 0);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("held_no_capture_estado", estado, 0);
    chk("held_no_capture_a", alu_a, 0);
    enter = 0;
    @(negedge clk);
    press(8'h5A, 3'd0);
    chk("repress_capture_a", alu_a, 8'h5A);
    chk("repress_estado", estado, 1);
    reset = 1; @(negedge clk); reset = 0;
    mdl_st = 0;
    txn(8'h12, 8'h34, 3'd0, 1);
    txn(8'h77, 8'h11, 3'd1, 99);
    txn(8'h80, 8'h80, 3'd0, TO);
    txn(8'h0F, 8'hF0, 3'd3, TO + 1);
    txn(8'h3C, 8'h3C, 3'd4, TO - 1);
    for (int i = 0; i < 30; i++)
      txn(8'($urandom), 8'($urandom), 3'($urandom), $urandom_range(1, 20));
    if (mdl_st == 0) press(8'hC3, 3'd0);
    cur_lat = 99;
    press(8'h99, 3'd2);
    repeat (3) @(negedge clk);
    chk("pre_reset_opera", estado, 2);
    reset = 1;
    @(negedge clk);
    chk("midrst_estado", estado, 0);
    chk("midrst_ab", {alu_a, alu_b}, 0);
    chk("midrst_op", alu_op, 0);
    chk("midrst_start", alu_start, 0);
    chk("midrst_res", {resultado, flags, erro}, 0);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sequenciador_rpn.md
# sequenciador_rpn

Control sequencer for the RPN calculator front end of the 8-bit ALU. It takes operands and the opcode from the board switches on each Enter press, drives the ALU request/response handshake, and holds the result and flags for the display. It owns the sequencer state and publishes it on `estado` for the display and debug LEDs.

## Interface
- `WIDTH`, 8, operand/result width
- `TIMEOUT_CICLOS`, 15, maximum cycles in OPERA waiting for `alu_valid` (1..255)

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `enter`  in  1  Enter button level, already synchronized/debounced
- `dado_in`  in  WIDTH  operand from switches
- `opcode`  in  3  ALU operation select
- `alu_a`, `alu_b`  out  WIDTH  registered operands to ALU
- `alu_op`  out  3  registered opcode to ALU
- `alu_start`  out  1  one-cycle request pulse
- `alu_valid`  in  1  ALU result valid
- `alu_result`  in  WIDTH  ALU result
- `alu_flags`  in  4  ALU flags {C,Z,N,V}
- `resultado`  out  WIDTH  held result
- `flags`  out  4  held flags
- `estado`  out  2  current state
- `erro`  out  1  ALU timeout indicator

## Operation
- Edge detection: `pulso = enter & ~enter_q`. `enter_q` is registered every cycle and resets to 1. A button held through reset produces no pulse until it is released and pressed again.
- States and encodings: ENTRA_A=00, ENTRA_B=01, OPERA=10, MOSTRA=11.
- **ENTRA_A**
  - On `pulso`: `alu_a <= dado_in`, then go to ENTRA_B.
- **ENTRA_B**
  - On `pulso`: `alu_b <= dado_in`, `alu_op <= opcode`, clear the timeout counter, then go to OPERA.
- **OPERA**
  - `alu_start` is high only in the first OPERA cycle.
  - The counter increments every OPERA cycle.
  - `alu_valid` high: `resultado <= alu_result`, `flags <= alu_flags`, `erro <= 0`, then go to MOSTRA.
  - Counter reaches `TIMEOUT_CICLOS - 1` without `alu_valid`: `resultado <= 0`, `flags <= 0`, `erro <= 1`, then go to MOSTRA.
  - `alu_valid` and timeout in the same cycle: `alu_valid` wins.
  - `pulso` is ignored in OPERA.
- **MOSTRA**
  - `resultado`, `flags` and `erro` are held.
  - On `pulso`, the next state depends on `RPN_CHAIN_EN` (see Configuration).
  - `erro` clears on leaving MOSTRA.
- `alu_valid` outside OPERA is ignored, and no output changes.
- `dado_in` and `opcode` are sampled only at the capturing edge.

## Timing
- Reset values: `estado` = 00, `alu_a` = `alu_b` = 0, `alu_op` = 0, `alu_start` = 0, `resultado` = 0, `flags` = 0, `erro` = 0, counter = 0.
- A `reset` asserted mid-operation (any state) wins over all other events at that edge.
- An operand is captured at the same edge where `pulso` is high, and `estado` changes at that edge.
- `alu_start` is asserted in the cycle after the ENTRA_B capture edge, for exactly 1 cycle.
- The result is registered at the first edge sampling `alu_valid` = 1. `resultado` and `estado` = 11 are visible in the following cycle.
- Minimum Enter-to-result latency with a combinational ALU (`alu_valid` tied to `alu_start`) is 2 cycles.
- Timeout: `erro` = 1 appears exactly `TIMEOUT_CICLOS` cycles after entering OPERA.

## Configuration
- `RPN_CHAIN_EN` defined:
  - `pulso` in MOSTRA with `erro` = 0: `alu_a <= resultado`, then go to ENTRA_B (chained RPN operation).
  - With `erro` = 1: go to ENTRA_A.
- `RPN_CHAIN_EN` not defined:
  - `pulso` in MOSTRA always goes to ENTRA_A.
  - `alu_a` is unchanged until the next capture.

## Structure
- Package `rpn_pkg` holds:
  - state encoding constants (ST_ENTRA_A..ST_MOSTRA)
  - `OPCODE_W` = 3
  - `FLAGS_W` = 4
  - flag bit positions
- One sub-module, `detector_borda_subida`: the registered `enter_q` with reset-to-1 and the `pulso` output.
- The FSM, operand/result registers and timeout counter live in the top module.

## Test plan
- **Basic sequence.** After reset, press Enter with `dado_in` = 8'h12, then with `dado_in` = 8'h34 and `opcode` = 3'b000; ALU model answers in 1 cycle with 8'h46, flags 4'b0000.
  - Expected: `alu_a` = 12, `alu_b` = 34, a single `alu_start` pulse, `resultado` = 46, `estado` = 11.
- **Timeout.** ALU never asserts `alu_valid`.
  - Expected: `erro` = 1, `resultado` = 0, `estado` = 11 exactly 15 cycles after entering OPERA. The next Enter returns `estado` = 00 and `erro` = 0.
- **Enter held.** Enter held high across reset release and held for 10 cycles.
  - Expected: no capture. One capture only after release and re-press. No capture while in OPERA.
- **Valid/timeout collision.** `alu_valid` in the 15th OPERA cycle.
  - Expected: result captured, `erro` = 0.
- **Chaining.** With `RPN_CHAIN_EN`, result 8'h46 then Enter.
  - Expected: `estado` = 01, `alu_a` = 46. Without the macro: `estado` = 00, `alu_a` = 12.
- **Reset mid-operation.** Assert `reset` during OPERA.
  - Expected: next cycle all outputs at reset values, `alu_start` = 0.
